// File: rtl/md_unit_if.sv
// Handshake and result bundle between the E-stage pipeline and the multiply/divide unit.
interface md_unit_if;
    logic        Start_MD_I;
    logic [3:0]  MDOp_MD_I;
    logic [31:0] A_MD_I;
    logic [31:0] B_MD_I;
    logic        Busy_MD_O;
    logic        StallE_MD_O;
    logic [31:0] HI_MD_O;
    logic [31:0] LO_MD_O;

    modport master (
        output Start_MD_I, MDOp_MD_I, A_MD_I, B_MD_I,
        input  Busy_MD_O, StallE_MD_O, HI_MD_O, LO_MD_O
    );

    modport slave (
        input  Start_MD_I, MDOp_MD_I, A_MD_I, B_MD_I,
        output Busy_MD_O, StallE_MD_O, HI_MD_O, LO_MD_O
    );
endinterface

// File: rtl/md_unit.sv
// E-stage multiply/divide unit owning HI/LO; results commit after a fixed latency.
// Define MD_MADD_EN to accept madd/maddu/msub/msubu as multiply-class ops.
module md_unit #(
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input logic      clk,
    input logic      reset,
    md_unit_if.slave md
);
    localparam int MAX_CYC = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0, OP_MULTU = 4'd1, OP_DIV  = 4'd2, OP_DIVU  = 4'd3,
        OP_MTHI  = 4'd4, OP_MTLO  = 4'd5, OP_MADD = 4'd6, OP_MADDU = 4'd7,
        OP_MSUB  = 4'd8, OP_MSUBU = 4'd9
    } op_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic [31:0]        hi_q, lo_q;
    logic [31:0]        shadow_hi_q, shadow_lo_q;
    logic [31:0]        shadow_hi_d, shadow_lo_d;

    logic is_mul, is_div, is_signed, is_acc, is_sub, is_mthi, is_mtlo;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        is_acc    = 1'b0;
        is_sub    = 1'b0;
        is_mthi   = 1'b0;
        is_mtlo   = 1'b0;
        case (md.MDOp_MD_I)
            OP_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
            OP_MULTU: is_mul = 1'b1;
            OP_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
            OP_DIVU:  is_div = 1'b1;
            OP_MTHI:  is_mthi = 1'b1;
            OP_MTLO:  is_mtlo = 1'b1;
`ifdef MD_MADD_EN
            OP_MADD:  begin is_mul = 1'b1; is_acc = 1'b1; is_signed = 1'b1; end
            OP_MADDU: begin is_mul = 1'b1; is_acc = 1'b1; end
            OP_MSUB:  begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; is_signed = 1'b1; end
            OP_MSUBU: begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
`endif
            default: ;
        endcase
    end

    // Sign-extending to 64 bits lets one 64x64 multiplier serve both signednesses.
    logic [63:0] a_ext, b_ext, prod, acc;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, div_den, quo_mag, rem_mag, quo, rem;

    always_comb begin
        a_ext   = {{32{is_signed & md.A_MD_I[31]}}, md.A_MD_I};
        b_ext   = {{32{is_signed & md.B_MD_I[31]}}, md.B_MD_I};
        prod    = a_ext * b_ext;
        acc     = {hi_q, lo_q};

        // Magnitude divide: handles 0x80000000 / -1 without a signed-overflow case.
        a_neg   = is_signed & md.A_MD_I[31];
        b_neg   = is_signed & md.B_MD_I[31];
        a_mag   = a_neg ? (~md.A_MD_I + 32'd1) : md.A_MD_I;
        b_mag   = b_neg ? (~md.B_MD_I + 32'd1) : md.B_MD_I;
        div_den = (b_mag == 32'd0) ? 32'd1 : b_mag;
        quo_mag = a_mag / div_den;
        rem_mag = a_mag % div_den;
        quo     = (a_neg ^ b_neg) ? (~quo_mag + 32'd1) : quo_mag;
        rem     = a_neg ? (~rem_mag + 32'd1) : rem_mag;

        {shadow_hi_d, shadow_lo_d} = {hi_q, lo_q};
        if (is_mul) begin
            if (is_acc) begin
                {shadow_hi_d, shadow_lo_d} = is_sub ? (acc - prod) : (acc + prod);
            end else begin
                {shadow_hi_d, shadow_lo_d} = prod;
            end
        end else if (is_div && (md.B_MD_I != 32'd0)) begin
            {shadow_hi_d, shadow_lo_d} = {rem, quo};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            shadow_hi_q <= '0;
            shadow_lo_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (md.Start_MD_I) begin
                        if (is_mul || is_div) begin
                            state_q     <= is_mul ? MUL : DIV;
                            cnt_q       <= is_mul ? CNT_W'(MUL_CYC) : CNT_W'(DIV_CYC);
                            busy_q      <= 1'b1;
                            shadow_hi_q <= shadow_hi_d;
                            shadow_lo_q <= shadow_lo_d;
                        end else if (is_mthi) begin
                            hi_q <= md.A_MD_I;
                        end else if (is_mtlo) begin
                            lo_q <= md.A_MD_I;
                        end
                    end
                end
                MUL, DIV: begin
                    if (cnt_q == CNT_W'(1)) begin
                        hi_q    <= shadow_hi_q;
                        lo_q    <= shadow_lo_q;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign md.Busy_MD_O   = busy_q;
    assign md.StallE_MD_O = busy_q | (md.Start_MD_I & (is_mul | is_div));
    assign md.HI_MD_O     = hi_q;
    assign md.LO_MD_O     = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, hand-written corner sequences,
// and randomized ops checked against a plain-arithmetic HI/LO model.
module tb_md_unit;
    localparam int MUL_CYC = 5;
    localparam int DIV_CYC = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_unit_if u_if ();

    md_unit #(.MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (u_if.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] m_hi, m_lo;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, exp_hi, exp_lo;
        int          exp_n;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] eh, input logic [31:0] el, input int n);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp_hi = eh; v.exp_lo = el; v.exp_n = n;
        return v;
    endfunction

    // Reference model: updates m_hi/m_lo from the architectural rules, returns busy length.
    function automatic int model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p, hl;
        int n;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hl = {m_hi, m_lo};
        n  = 0;
        case (op)
            4'd0: begin p = 64'(sa * sb); {m_hi, m_lo} = p; n = MUL_CYC; end
            4'd1: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; n = MUL_CYC; end
            4'd2: begin
                if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
                n = DIV_CYC;
            end
            4'd3: begin
                if (b != 0) begin m_lo = a / b; m_hi = a % b; end
                n = DIV_CYC;
            end
            4'd4: m_hi = a;
            4'd5: m_lo = a;
`ifdef MD_MADD_EN
            4'd6: begin p = 64'(sa * sb); {m_hi, m_lo} = hl + p; n = MUL_CYC; end
            4'd7: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = hl + p; n = MUL_CYC; end
            4'd8: begin p = 64'(sa * sb); {m_hi, m_lo} = hl - p; n = MUL_CYC; end
            4'd9: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = hl - p; n = MUL_CYC; end
`endif
            default: ;
        endcase
        return n;
    endfunction

    // Called at a falling edge; returns at the falling edge of the first idle cycle.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int exp_n, input string name);
        int busy_n;
        bit stall_ok;
        busy_n   = 0;
        stall_ok = 1'b1;
        u_if.Start_MD_I = 1'b1;
        u_if.MDOp_MD_I  = op;
        u_if.A_MD_I     = a;
        u_if.B_MD_I     = b;
        #1 check({name, " stall_issue"}, 64'(u_if.StallE_MD_O), 64'(exp_n > 0));
        @(negedge clk);
        u_if.Start_MD_I = 1'b0;
        u_if.MDOp_MD_I  = 4'hF;
        while (u_if.Busy_MD_O && busy_n < 200) begin
            busy_n++;
            if (!u_if.StallE_MD_O) stall_ok = 1'b0;
            @(negedge clk);
        end
        check({name, " busy_cycles"}, 64'(busy_n), 64'(exp_n));
        check({name, " stall_while_busy"}, 64'(stall_ok), 64'd1);
        check({name, " stall_after"}, 64'(u_if.StallE_MD_O), 64'd0);
        check({name, " hi"}, 64'(u_if.HI_MD_O), 64'(exp_hi));
        check({name, " lo"}, 64'(u_if.LO_MD_O), 64'(exp_lo));
    endtask

    initial begin
        int busy_n, n;
        logic [3:0] op;
        logic [31:0] a, b;

        reset = 1'b0;
        u_if.Start_MD_I = 1'b0;
        u_if.MDOp_MD_I  = 4'hF;
        u_if.A_MD_I     = '0;
        u_if.B_MD_I     = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(u_if.Busy_MD_O), 64'd0);
        check("reset hi", 64'(u_if.HI_MD_O), 64'd0);
        check("reset lo", 64'(u_if.LO_MD_O), 64'd0);
        check("reset stall_idle", 64'(u_if.StallE_MD_O), 64'd0);
        u_if.Start_MD_I = 1'b1;
        u_if.MDOp_MD_I  = 4'd0;
        #1 check("reset stall_start_term", 64'(u_if.StallE_MD_O), 64'd1);
        u_if.Start_MD_I = 1'b0;
        u_if.MDOp_MD_I  = 4'hF;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        m_hi = '0;
        m_lo = '0;

        vecs.push_back(mk(4'd4, 32'h11, 32'h0, 32'h11, 32'h0, 0));
        vecs.push_back(mk(4'd5, 32'h22, 32'h0, 32'h11, 32'h22, 0));
        vecs.push_back(mk(4'd2, 32'h1234, 32'h0, 32'h11, 32'h22, DIV_CYC));
        vecs.push_back(mk(4'd0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_CYC));
        vecs.push_back(mk(4'd1, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, MUL_CYC));
        vecs.push_back(mk(4'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_CYC));
        vecs.push_back(mk(4'd3, 32'd7, 32'd2, 32'd1, 32'd3, DIV_CYC));
        vecs.push_back(mk(4'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, DIV_CYC));
        vecs.push_back(mk(4'd12, 32'd5, 32'd5, 32'h0, 32'h80000000, 0));
        vecs.push_back(mk(4'd5, 32'hFFFFFFFF, 32'd0, 32'h0, 32'hFFFFFFFF, 0));
`ifdef MD_MADD_EN
        vecs.push_back(mk(4'd6, 32'd1, 32'd1, 32'h1, 32'h0, MUL_CYC));
`else
        vecs.push_back(mk(4'd6, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 0));
`endif

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
                   vecs[i].exp_n, $sformatf("vec%0d", i));
            m_hi = vecs[i].exp_hi;
            m_lo = vecs[i].exp_lo;
        end

        // Back-to-back multiplies: second issued in the first cycle Busy is low.
        n = model_op(4'd0, 32'h00012345, 32'hFFFF0003);
        run_op(4'd0, 32'h00012345, 32'hFFFF0003, m_hi, m_lo, n, "b2b_first");
        n = model_op(4'd1, 32'hDEADBEEF, 32'h00C0FFEE);
        run_op(4'd1, 32'hDEADBEEF, 32'h00C0FFEE, m_hi, m_lo, n, "b2b_second");

        // mthi presented while a divide-by-zero is busy must be dropped.
        run_op(4'd4, 32'h11, 32'h0, 32'h11, m_lo, 0, "pre_mthi");
        run_op(4'd5, 32'h22, 32'h0, 32'h11, 32'h22, 0, "pre_mtlo");
        u_if.Start_MD_I = 1'b1;
        u_if.MDOp_MD_I  = 4'd2;
        u_if.A_MD_I     = 32'h1234;
        u_if.B_MD_I     = 32'h0;
        @(negedge clk);
        u_if.MDOp_MD_I  = 4'd4;
        u_if.A_MD_I     = 32'h55;
        #1 check("mthi_busy stall", 64'(u_if.StallE_MD_O), 64'd1);
        check("mthi_busy busy", 64'(u_if.Busy_MD_O), 64'd1);
        @(negedge clk);
        u_if.Start_MD_I = 1'b0;
        u_if.MDOp_MD_I  = 4'hF;
        busy_n = 1;
        while (u_if.Busy_MD_O && busy_n < 200) begin
            busy_n++;
            @(negedge clk);
        end
        check("mthi_busy busy_cycles", 64'(busy_n), 64'(DIV_CYC));
        check("mthi_busy hi", 64'(u_if.HI_MD_O), 64'h11);
        check("mthi_busy lo", 64'(u_if.LO_MD_O), 64'h22);
        m_hi = 32'h11;
        m_lo = 32'h22;

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
            n = model_op(op, a, b);
            run_op(op, a, b, m_hi, m_lo, n, $sformatf("rand%0d_op%0d", i, op));
        end

        // Reset in the third busy cycle of a divide aborts it; nothing commits later.
        run_op(4'd4, 32'hAA, 32'h0, 32'hAA, m_lo, 0, "abort_pre");
        u_if.Start_MD_I = 1'b1;
        u_if.MDOp_MD_I  = 4'd3;
        u_if.A_MD_I     = 32'd100;
        u_if.B_MD_I     = 32'd7;
        @(negedge clk);
        u_if.Start_MD_I = 1'b0;
        u_if.MDOp_MD_I  = 4'hF;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1 check("abort busy", 64'(u_if.Busy_MD_O), 64'd0);
        check("abort hi", 64'(u_if.HI_MD_O), 64'd0);
        check("abort lo", 64'(u_if.LO_MD_O), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (DIV_CYC + 3) @(negedge clk);
        check("abort no_commit busy", 64'(u_if.Busy_MD_O), 64'd0);
        check("abort no_commit hi", 64'(u_if.HI_MD_O), 64'd0);
        check("abort no_commit lo", 64'(u_if.LO_MD_O), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- E-stage multiply/divide unit owning the HI/LO register pair.
- Executes mult/multu/div/divu over a fixed multi-cycle latency and performs mthi/mtlo writes.
- Drives the E-stage stall indication that the pipeline hazard controller consumes to freeze D and flush E for following mult/div/mfhi/mflo/mthi/mtlo.
- Is the producer side of that stall handshake.

Parameters:
- MUL_CYC, 5: busy cycles for multiply-class ops; must be >= 1.
- DIV_CYC, 10: busy cycles for divide-class ops; must be >= 1.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- Start_MD_I  in  1  E-stage instruction is a valid MD op this cycle.
- MDOp_MD_I  in  4  op code: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu, 8 msub, 9 msubu; 10-15 no-op.
- A_MD_I  in  32  rs operand (forwarded).
- B_MD_I  in  32  rt operand (forwarded).
- Busy_MD_O  out  1  long op in progress (state != IDLE).
- StallE_MD_O  out  1  Busy_MD_O | (Start_MD_I & op is mult/div-class); combinational.
- HI_MD_O  out  32  architectural HI.
- LO_MD_O  out  32  architectural LO.

Behaviour:
- Reset (reset low, async): state IDLE, counter 0, HI=0, LO=0, Busy=0. StallE then equals Start-qualified term only. Reset mid-operation aborts the op; the pending result is discarded.
- States: IDLE, MUL, DIV. Op is accepted only when Start=1 and state=IDLE.
  - Start ignored while Busy=1 (hazard controller guarantees no issue). mthi/mtlo in that case also ignored.
- mthi/mtlo, accepted at edge t: HI (or LO) <= A at that edge. No busy, no stall.
- mult/multu, accepted at edge t:
  - Compute 64-bit product (signed for mult, unsigned for multu) into shadow {hi_n, lo_n}.
  - state <= MUL, cnt <= MUL_CYC.
- div/divu: compute quotient/remainder into shadow; state <= DIV, cnt <= DIV_CYC.
  - Signed divide truncates toward zero; remainder takes the sign of the dividend. LO=quotient, HI=remainder.
  - 0x80000000 / 0xFFFFFFFF signed: LO=0x80000000, HI=0.
  - B=0: full DIV_CYC busy, HI/LO left unchanged at commit.
- In MUL/DIV, each edge: if cnt==1, commit shadow to HI/LO and go to IDLE; else cnt <= cnt-1.
- Timing: Start high in cycle t.
  - StallE=1 in cycles t..t+N (N = MUL_CYC or DIV_CYC).
  - Busy=1 in t+1..t+N.
  - New HI/LO visible from cycle t+N+1, when Busy=0.
- A new Start in the cycle after Busy falls is accepted normally; back-to-back ops are legal.
- HI/LO outputs are registers only; mfhi/mflo read them directly and are held by the stall until the commit.
- Invalid MDOp with Start=1: no state change, no stall.

Optional Feature:
- MD_MADD_EN defined: ops 6-9 are accepted as multiply-class (MUL state, MUL_CYC latency, StallE asserted).
  - Shadow = {HI,LO} + product (madd signed, maddu unsigned) or {HI,LO} - product (msub/msubu), using HI/LO values at accept edge. 64-bit wrap-around, no overflow flag.
- MD_MADD_EN undefined: ops 6-9 are no-ops identical to 10-15; StallE not asserted for them.

Test Plan:
- Reset low mid-DIV (cycle 3 of 10), release -> Busy=0, HI=LO=0 immediately; no commit afterwards.
- mult A=0xFFFFFFFF, B=2 -> Busy 5 cycles, StallE 6 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same with multu -> HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 -> LO=3, HI=1.
- Preload HI=0x11, LO=0x22 via mthi/mtlo. Then div B=0 -> Busy 10 cycles, HI=0x11, LO=0x22 unchanged. Then mthi 0x55 with Start during Busy -> ignored, HI stays 0x11.
- mult accepted, second mult presented the cycle Busy falls -> accepted, total 10 busy cycles, final HI/LO = second product.
- MD_MADD_EN defined: HI=0, LO=0xFFFFFFFF, madd A=1, B=1 -> HI=1, LO=0. Undefined: same stimulus -> no stall, HI/LO unchanged.
